imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, the maximum consecutive loader beats before fetch is served.
REQ-002 The block SHALL have parameter ADDR_W, default 32, the byte-address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1, the reset, asynchronous and active-low.
REQ-005 The block SHALL have port f_req, input, 1, the fetch request from the core.
REQ-006 The block SHALL have port f_addr, input, ADDR_W, the fetch byte address.
REQ-007 The block SHALL have ports f_gnt (output, 1, fetch granted this cycle), f_rdata (output, 32, fetched instruction) and f_rvalid (output, 1, f_rdata valid).
REQ-008 The block SHALL have ports l_req, l_we, l_last (inputs, 1 each), meaning loader request, write enable and final beat.
REQ-009 The block SHALL have ports l_addr (input, ADDR_W) and l_wdata (input, 32).
REQ-010 The block SHALL have ports l_gnt (output, 1), l_rdata (output, 32) and l_rvalid (output, 1).
REQ-011 The block SHALL have ports mem_A (output, ADDR_W), mem_WD (output, 32), mem_WE (output, 1) and mem_RD (input, 32), the single-ported instruction memory with combinational read and synchronous write.
REQ-012 The block SHALL have ports halt (output, 1, core stall while the loader owns memory) and err (output, 1, sticky misaligned-write flag).

Function
REQ-013 FSM states SHALL be IDLE, FETCH, LOAD and YIELD, with state registered.
REQ-014 IDLE: l_req high SHALL go to LOAD (loader wins a tie); otherwise f_req high SHALL go to FETCH; otherwise stay in IDLE.
REQ-015 FETCH: l_req SHALL go to LOAD next cycle; otherwise !f_req SHALL go to IDLE.
REQ-016 LOAD: a granted beat with l_last SHALL go to FETCH if f_req, else IDLE.
REQ-017 LOAD: !l_req SHALL go to IDLE.
REQ-018 LOAD: a beat count reaching MAX_BURST with f_req high SHALL go to YIELD.
REQ-019 YIELD SHALL last exactly one cycle and grant fetch once, then go to LOAD if l_req, else FETCH if f_req, else IDLE.
REQ-020 Grants SHALL be combinational: f_gnt = f_req in FETCH or YIELD; l_gnt = l_req in LOAD.
REQ-021 f_gnt and l_gnt SHALL never both be high.
REQ-022 mem_A SHALL be the granted requester's address with bits [1:0] forced to 0, and 0 when nothing is granted.
REQ-023 mem_WE SHALL equal l_gnt & l_we & (l_addr[1:0]==0), with mem_WD = l_wdata.
REQ-024 A misaligned loader write SHALL be suppressed, still consume the beat, and set err until reset.
REQ-025 Read latency SHALL be 1 cycle: on a grant, mem_RD is registered into the requester's rdata and its rvalid pulses high the next cycle.
REQ-026 l_rvalid SHALL pulse only on loader reads (l_we=0).
REQ-027 The beat counter SHALL increment on each l_gnt, clear on leaving LOAD or entering YIELD, and saturate at MAX_BURST.
REQ-028 halt SHALL be registered and high exactly while state is LOAD.
REQ-029 A request withdrawn before its grant SHALL produce no memory access and no rvalid.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, counter 0, and f_rdata, l_rdata, f_rvalid, l_rvalid, halt and err to 0.
REQ-031 While rst is low, mem_WE SHALL be 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no partial write after reset assertion.
REQ-033 The first grant after reset release SHALL occur no earlier than the first rising clk edge with rst high.

Structure
REQ-034 Package imem_arb_pkg SHALL hold the state enum, the default MAX_BURST, and the word-alignment mask constant.
REQ-035 Sub-module imem_burst_counter SHALL implement the saturating beat counter (inc, clr, at_max).

Verification
REQ-036 Reset scenario: hold rst=0 with f_req=1 -> f_gnt=0, mem_WE=0, all outputs 0, state IDLE.
REQ-037 Fetch scenario: rst=1, f_req=1, f_addr=0, mem_RD=0x0062E233 -> f_gnt same cycle, f_rdata=0x0062E233 and f_rvalid=1 next cycle; f_addr=4 with mem_RD=0x00B62423 -> f_rdata=0x00B62423.
REQ-038 Tie scenario: in IDLE, f_req=l_req=1, l_we=1, l_addr=8, l_wdata=0x12345678 -> l_gnt, mem_WE=1, mem_A=8, halt=1 next cycle, f_gnt=0.
REQ-039 Fairness scenario: 20-beat loader burst with f_req held high -> exactly one f_gnt after beat 16 (YIELD), then loader resumes; beats 17-20 complete; l_last -> FETCH.
REQ-040 Misaligned scenario: l_we=1, l_addr=6 -> mem_WE=0, err=1 and sticky until rst=0.
REQ-041 Mid-burst reset scenario: rst=0 during beat 3 of a burst -> immediate IDLE, halt=0, no further mem_WE.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter between the
// core fetch port and the program loader.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        YIELD = 2'd3
    } arb_state_t;

    localparam int unsigned DEFAULT_MAX_BURST = 16;

    // Wide enough for any supported address width; the top slices it down.
    localparam int unsigned MASK_W = 64;
    localparam logic [MASK_W-1:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/imem_burst_counter.sv
// Saturating count of consecutive loader beats, used to force a fetch slot
// once the loader has held memory for MAX_BURST beats.
module imem_burst_counter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_CNT)) begin
            count <= count + CNT_W'(1);
        end
    end

    // High when the limit is already reached or is reached by the beat being
    // granted right now, so the FSM can yield without granting an extra beat.
    assign at_max = (count == MAX_CNT) || (inc && (count == MAX_CNT - CNT_W'(1)));

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a single-ported instruction memory between core fetch and a
// loader, with loader priority, bounded loader bursts and 1-cycle read data.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic [31:0]       f_rdata,
    output logic              f_rvalid,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_last,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic [31:0]       l_rdata,
    output logic              l_rvalid,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_WD,
    output logic              mem_WE,
    input  logic [31:0]       mem_RD,
    output logic              halt,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = WORD_ALIGN_MASK[ADDR_W-1:0];

    arb_state_t state;
    arb_state_t next_state;
    logic       at_max;
    logic       misaligned;
    logic       burst_clr;

    always_comb begin
        f_gnt      = f_req && ((state == FETCH) || (state == YIELD));
        l_gnt      = l_req && (state == LOAD);
        misaligned = (l_addr[1:0] != 2'b00);
        mem_WE     = l_gnt && l_we && !misaligned;
        mem_WD     = l_wdata;
        if (f_gnt) begin
            mem_A = f_addr & ADDR_MASK;
        end else if (l_gnt) begin
            mem_A = l_addr & ADDR_MASK;
        end else begin
            mem_A = '0;
        end
    end

    // Loader wins ties; a finishing beat takes precedence over the yield check.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (l_req)      next_state = LOAD;
                else if (f_req) next_state = FETCH;
            end
            FETCH: begin
                if (l_req)       next_state = LOAD;
                else if (!f_req) next_state = IDLE;
            end
            LOAD: begin
                if (l_gnt && l_last)      next_state = f_req ? FETCH : IDLE;
                else if (!l_req)          next_state = IDLE;
                else if (f_req && at_max) next_state = YIELD;
            end
            YIELD: begin
                if (l_req)      next_state = LOAD;
                else if (f_req) next_state = FETCH;
                else            next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign burst_clr = (state == LOAD) && (next_state != LOAD);

    imem_burst_counter #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (l_gnt),
        .clr   (burst_clr),
        .at_max(at_max)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            halt     <= 1'b0;
            err      <= 1'b0;
            f_rdata  <= '0;
            f_rvalid <= 1'b0;
            l_rdata  <= '0;
            l_rvalid <= 1'b0;
        end else begin
            state    <= next_state;
            halt     <= (next_state == LOAD);
            f_rvalid <= f_gnt;
            l_rvalid <= l_gnt && !l_we;
            if (f_gnt) begin
                f_rdata <= mem_RD;
            end
            if (l_gnt && !l_we) begin
                l_rdata <= mem_RD;
            end
            if (l_gnt && l_we && misaligned) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reset, fetch, tie, burst fairness,
// misaligned write and mid-burst reset, each with hand-computed expectations.
module tb_imem_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MAX_BURST = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic [31:0]       f_rdata;
    logic              f_rvalid;
    logic              l_req;
    logic              l_we;
    logic              l_last;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic [31:0]       l_rdata;
    logic              l_rvalid;
    logic [ADDR_W-1:0] mem_A;
    logic [31:0]       mem_WD;
    logic              mem_WE;
    logic [31:0]       mem_RD;
    logic              halt;
    logic              err;

    int tests_run    = 0;
    int tests_failed = 0;

    imem_arbiter #(
        .MAX_BURST(MAX_BURST),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .f_req   (f_req),
        .f_addr  (f_addr),
        .f_gnt   (f_gnt),
        .f_rdata (f_rdata),
        .f_rvalid(f_rvalid),
        .l_req   (l_req),
        .l_we    (l_we),
        .l_last  (l_last),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_gnt   (l_gnt),
        .l_rdata (l_rdata),
        .l_rvalid(l_rvalid),
        .mem_A   (mem_A),
        .mem_WD  (mem_WD),
        .mem_WE  (mem_WE),
        .mem_RD  (mem_RD),
        .halt    (halt),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and settle before checks.
    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic lr,
                                 input logic lw, input logic ll, input logic [31:0] la,
                                 input logic [31:0] ld, input logic [31:0] rd);
        f_req   = fr;
        f_addr  = fa;
        l_req   = lr;
        l_we    = lw;
        l_last  = ll;
        l_addr  = la;
        l_wdata = ld;
        mem_RD  = rd;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beat;
        int yield_count;
        int yield_after;
        int both_high;
        int halt_bad;

        rst = 1'b0;
        applyStimulus(1, 32'h0, 1, 1, 0, 32'h0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("rst_f_gnt",    f_gnt,    0);
        checkOutput("rst_l_gnt",    l_gnt,    0);
        checkOutput("rst_mem_we",   mem_WE,   0);
        checkOutput("rst_mem_a",    mem_A,    0);
        checkOutput("rst_halt",     halt,     0);
        checkOutput("rst_err",      err,      0);
        checkOutput("rst_f_rvalid", f_rvalid, 0);
        checkOutput("rst_l_rvalid", l_rvalid, 0);
        checkOutput("rst_f_rdata",  f_rdata,  0);
        checkOutput("rst_l_rdata",  l_rdata,  0);

        // Release reset mid-cycle: no grant may appear before the next edge.
        rst = 1'b1;
        applyStimulus(1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0062E233);
        checkOutput("rel_f_gnt_early", f_gnt, 0);
        nextCycle();
        checkOutput("fetch0_gnt",    f_gnt,    1);
        checkOutput("fetch0_mem_a",  mem_A,    32'h0);
        checkOutput("fetch0_rvalid", f_rvalid, 0);
        nextCycle();
        checkOutput("fetch0_rdata",   f_rdata,  32'h0062E233);
        checkOutput("fetch0_rvalid1", f_rvalid, 1);
        checkOutput("fetch_halt",     halt,     0);
        applyStimulus(1, 32'h4, 0, 0, 0, 32'h0, 32'h0, 32'h00B62423);
        checkOutput("fetch4_mem_a", mem_A, 32'h4);
        checkOutput("fetch4_l_gnt", l_gnt, 0);
        nextCycle();
        checkOutput("fetch4_rdata", f_rdata, 32'h00B62423);
        applyStimulus(1, 32'h13, 0, 0, 0, 32'h0, 32'h0, 32'hA5A5A5A5);
        checkOutput("fetch13_mem_a", mem_A, 32'h10);
        nextCycle();
        checkOutput("fetch13_rdata", f_rdata, 32'hA5A5A5A5);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        checkOutput("fetch_drop_gnt",   f_gnt, 0);
        checkOutput("fetch_drop_mem_a", mem_A, 0);
        nextCycle();
        checkOutput("fetch_drop_rvalid", f_rvalid, 0);
        checkOutput("fetch_hold_rdata",  f_rdata,  32'hA5A5A5A5);

        // Tie in IDLE: loader wins, first beat is an aligned write.
        applyStimulus(1, 32'h40, 1, 1, 0, 32'h8, 32'h12345678, 32'h0);
        checkOutput("tie_idle_f_gnt", f_gnt, 0);
        checkOutput("tie_idle_l_gnt", l_gnt, 0);
        nextCycle();
        checkOutput("tie_l_gnt",  l_gnt,  1);
        checkOutput("tie_f_gnt",  f_gnt,  0);
        checkOutput("tie_mem_we", mem_WE, 1);
        checkOutput("tie_mem_a",  mem_A,  32'h8);
        checkOutput("tie_mem_wd", mem_WD, 32'h12345678);
        checkOutput("tie_halt",   halt,   1);
        nextCycle();
        checkOutput("tie_wr_l_rvalid", l_rvalid, 0);
        applyStimulus(1, 32'h40, 1, 0, 1, 32'hC, 32'h0, 32'hCAFEF00D);
        checkOutput("tie_rd_l_gnt",  l_gnt,  1);
        checkOutput("tie_rd_mem_we", mem_WE, 0);
        checkOutput("tie_rd_mem_a",  mem_A,  32'hC);
        nextCycle();
        applyStimulus(1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        checkOutput("tie_l_rdata",   l_rdata,  32'hCAFEF00D);
        checkOutput("tie_l_rvalid",  l_rvalid, 1);
        checkOutput("tie_end_halt",  halt,     0);
        checkOutput("tie_end_f_gnt", f_gnt,    1);
        checkOutput("tie_end_mem_a", mem_A,    32'h40);
        nextCycle();
        checkOutput("tie_l_rvalid_pulse", l_rvalid, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        nextCycle();

        // 20-beat burst with fetch pending: one fetch slot after beat 16.
        applyStimulus(1, 32'h100, 1, 1, 0, 32'h0, 32'h0, 32'h0);
        nextCycle();
        beat        = 1;
        yield_count = 0;
        yield_after = 0;
        both_high   = 0;
        halt_bad    = 0;
        for (int cyc = 0; cyc < 30 && beat <= 20; cyc++) begin
            applyStimulus(1, 32'h100, 1, 1, (beat == 20), 32'(beat * 4), 32'(beat), 32'h0);
            if (f_gnt && l_gnt) both_high++;
            if (halt !== l_gnt) halt_bad++;
            if (l_gnt && mem_WE && (mem_A == 32'(beat * 4))) begin
                beat++;
            end else if (f_gnt) begin
                yield_count++;
                yield_after = beat - 1;
            end
            nextCycle();
        end
        checkOutput("burst_beats",       beat,        21);
        checkOutput("burst_yield_count", yield_count, 1);
        checkOutput("burst_yield_after", yield_after, 16);
        checkOutput("burst_both_high",   both_high,   0);
        checkOutput("burst_halt",        halt_bad,    0);
        applyStimulus(1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        checkOutput("burst_end_f_gnt", f_gnt, 1);
        checkOutput("burst_end_halt",  halt,  0);
        checkOutput("burst_end_mem_a", mem_A, 32'h100);
        nextCycle();
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        nextCycle();

        // Misaligned loader write is dropped but still consumes the beat.
        applyStimulus(0, 32'h0, 1, 1, 1, 32'h6, 32'hDEADBEEF, 32'h0);
        nextCycle();
        checkOutput("mis_l_gnt",  l_gnt,  1);
        checkOutput("mis_mem_we", mem_WE, 0);
        checkOutput("mis_mem_a",  mem_A,  32'h4);
        checkOutput("mis_err_pre", err,   0);
        nextCycle();
        checkOutput("mis_err",  err,  1);
        checkOutput("mis_halt", halt, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("mis_err_sticky", err, 1);

        // Reset asserted during beat 3 of a write burst.
        applyStimulus(0, 32'h0, 1, 1, 0, 32'h20, 32'h55, 32'h0);
        nextCycle();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(0, 32'h0, 1, 1, 0, 32'(32'h20 + b * 4), 32'h55, 32'h0);
            nextCycle();
        end
        applyStimulus(0, 32'h0, 1, 1, 0, 32'h28, 32'h55, 32'h0);
        checkOutput("mid_beat3_we", mem_WE, 1);
        rst = 1'b0;
        #1;
        checkOutput("mid_l_gnt",  l_gnt,  0);
        checkOutput("mid_mem_we", mem_WE, 0);
        checkOutput("mid_halt",   halt,   0);
        checkOutput("mid_err",    err,    0);
        checkOutput("mid_mem_a",  mem_A,  0);
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            checkOutput("mid_hold_we",   mem_WE, 0);
            checkOutput("mid_hold_halt", halt,   0);
        end
        rst = 1'b1;
        #1;
        checkOutput("mid_rel_l_gnt", l_gnt, 0);
        nextCycle();
        checkOutput("mid_after_l_gnt", l_gnt, 1);
        checkOutput("mid_after_halt",  halt,  1);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        nextCycle();
        checkOutput("mid_final_halt", halt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
